// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS PC sequencer with boot delay, req/ready fetch, latched redirects and exception entry
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
   parameter int          BOOT_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   output logic        instr_valid,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exc,
   output logic [31:0] pc_out,
   output logic [31:0] epc,
   output logic        misaligned
);
   typedef enum logic [1:0] {BOOT, FETCH, EXC} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic        pend;
   logic [31:0] pend_tgt;
   logic        acc, redir, bad, exc_now;
   logic [31:0] tgt, next_pc;
   assign imem_req  = (state == FETCH) & ~stall;
   assign imem_addr = pc_out;
   assign acc       = imem_req & imem_ready;
   assign redir     = jump | branch_taken | pend;
   assign tgt       = jump ? jump_target : branch_taken ? branch_target : pend_tgt;
   assign next_pc   = redir ? tgt : pc_out + 32'd4;
   assign bad       = acc & redir & (tgt[1:0] != 2'b00);
   assign exc_now   = (state == FETCH) & (exc | bad);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         cnt         <= '0;
         pc_out      <= RESET_VECTOR;
         epc         <= '0;
         misaligned  <= 1'b0;
         instr_valid <= 1'b0;
         pend        <= 1'b0;
         pend_tgt    <= '0;
      end else begin
         instr_valid <= acc & ~exc_now;
         if (state == BOOT) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(BOOT_CYCLES - 1)) state <= FETCH;
         end else if (state == EXC) begin
            state <= FETCH;
         end else if (exc_now) begin
            epc        <= pc_out;
            pc_out     <= EXC_VECTOR;
            pend       <= 1'b0;
            misaligned <= misaligned | bad;
            state      <= EXC;
         end else if (acc) begin
            pc_out <= next_pc;
            pend   <= 1'b0;
         end else if (jump | branch_taken) begin
            pend     <= 1'b1;
            pend_tgt <= jump ? jump_target : branch_target;
         end
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        instr_valid;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        exc = 1'b0;
   logic [31:0] pc_out;
   logic [31:0] epc;
   logic        misaligned;
   int          total = 0;
   int          passed = 0;
   pc_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .instr_valid(instr_valid),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .exc(exc), .pc_out(pc_out), .epc(epc), .misaligned(misaligned)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic nxt;
      @(posedge clk);
      #2;
   endtask
   initial begin
      nxt;
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_mis", 32'(misaligned), 32'h0);
      chk("rst_iv", 32'(instr_valid), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      reset = 1'b1;
      imem_ready = 1'b1;
      #1 chk("boot0_req", 32'(imem_req), 32'h0);
      nxt;
      chk("boot1_req", 32'(imem_req), 32'h0);
      nxt;
      chk("boot2_req", 32'(imem_req), 32'h1);
      chk("boot2_pc", pc_out, 32'h0);
      chk("boot2_addr", imem_addr, 32'h0);
      chk("boot2_iv", 32'(instr_valid), 32'h0);
      nxt;
      chk("seq_pc4", pc_out, 32'h4);
      chk("seq_iv4", 32'(instr_valid), 32'h1);
      nxt;
      chk("seq_pc8", pc_out, 32'h8);
      chk("seq_iv8", 32'(instr_valid), 32'h1);
      nxt;
      chk("seq_pcc", pc_out, 32'hC);
      chk("seq_ivc", 32'(instr_valid), 32'h1);
      nxt;
      chk("seq_pc10", pc_out, 32'h10);
      imem_ready = 1'b0;
      branch_taken = 1'b1;
      branch_target = 32'h40;
      nxt;
      branch_taken = 1'b0;
      chk("wait1_pc", pc_out, 32'h10);
      chk("wait1_iv", 32'(instr_valid), 32'h0);
      nxt;
      chk("wait2_pc", pc_out, 32'h10);
      nxt;
      chk("wait3_pc", pc_out, 32'h10);
      imem_ready = 1'b1;
      nxt;
      chk("pend_br_pc", pc_out, 32'h40);
      chk("pend_br_iv", 32'(instr_valid), 32'h1);
      jump = 1'b1;
      jump_target = 32'h100;
      branch_taken = 1'b1;
      branch_target = 32'h200;
      nxt;
      chk("jmp_over_br", pc_out, 32'h100);
      jump = 1'b0;
      branch_taken = 1'b0;
      nxt;
      chk("after_jmp", pc_out, 32'h104);
      stall = 1'b1;
      jump = 1'b1;
      branch_taken = 1'b1;
      #1 chk("stall_req", 32'(imem_req), 32'h0);
      nxt;
      chk("stall1_pc", pc_out, 32'h104);
      chk("stall1_iv", 32'(instr_valid), 32'h0);
      nxt;
      chk("stall2_pc", pc_out, 32'h104);
      stall = 1'b0;
      nxt;
      chk("stall_jmp", pc_out, 32'h100);
      branch_taken = 1'b0;
      jump_target = 32'h24;
      nxt;
      jump = 1'b0;
      chk("to24", pc_out, 32'h24);
      exc = 1'b1;
      #1 chk("exc_req_before", 32'(imem_req), 32'h1);
      nxt;
      exc = 1'b0;
      #1;
      chk("exc_epc", epc, 32'h24);
      chk("exc_pc", pc_out, 32'h8000_0180);
      chk("exc_iv", 32'(instr_valid), 32'h0);
      chk("exc_req", 32'(imem_req), 32'h0);
      nxt;
      chk("exc_resume_req", 32'(imem_req), 32'h1);
      chk("exc_resume_pc", pc_out, 32'h8000_0180);
      nxt;
      chk("exc_next_pc", pc_out, 32'h8000_0184);
      chk("exc_next_iv", 32'(instr_valid), 32'h1);
      jump = 1'b1;
      jump_target = 32'h30;
      nxt;
      jump = 1'b0;
      chk("to30", pc_out, 32'h30);
      chk("mis_before", 32'(misaligned), 32'h0);
      branch_taken = 1'b1;
      branch_target = 32'h42;
      nxt;
      branch_taken = 1'b0;
      chk("mis_flag", 32'(misaligned), 32'h1);
      chk("mis_epc", epc, 32'h30);
      chk("mis_pc", pc_out, 32'h8000_0180);
      chk("mis_iv", 32'(instr_valid), 32'h0);
      nxt;
      nxt;
      chk("mis_resume_pc", pc_out, 32'h8000_0184);
      nxt;
      chk("mis_sticky", 32'(misaligned), 32'h1);
      chk("mis_fetch_pc", pc_out, 32'h8000_0188);
      jump = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      nxt;
      jump = 1'b0;
      chk("to_top", pc_out, 32'hFFFF_FFFC);
      nxt;
      chk("wrap_pc", pc_out, 32'h0);
      nxt;
      chk("wrap_next", pc_out, 32'h4);
      chk("pre_rst_req", 32'(imem_req), 32'h1);
      reset = 1'b0;
      #1;
      chk("arst_req", 32'(imem_req), 32'h0);
      chk("arst_pc", pc_out, 32'h0);
      chk("arst_epc", epc, 32'h0);
      chk("arst_mis", 32'(misaligned), 32'h0);
      chk("arst_iv", 32'(instr_valid), 32'h0);
      nxt;
      reset = 1'b1;
      exc = 1'b1;
      nxt;
      nxt;
      exc = 1'b0;
      #1;
      chk("boot_exc_req", 32'(imem_req), 32'h1);
      chk("boot_exc_pc", pc_out, 32'h0);
      chk("boot_exc_epc", epc, 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
